arb2_rr: RTL and testbench

ARB2_RR -- requirements
Module: arb2_rr

---
 rtl/arb2_rr.sv | 83 ++++++++
 tb/tb_arb2_rr.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/arb2_rr.sv
// arb2_rr: two-channel round-robin arbiter feeding a single registered output slot.
// Channels a and b compete for the slot; s records which channel supplied y.
// A one-bit priority pointer alternates the winner under sustained contention.
module arb2_rr #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] a,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [W-1:0] b,
    input  logic         b_valid,
    output logic         b_ready,
    output logic [W-1:0] y,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         s
);

    typedef enum logic [0:0] {StEmpty, StFull} state_t;

    state_t       state_q, state_d;
    logic [W-1:0] y_q, y_d;
    logic         s_q, s_d;
    logic         ptr_q, ptr_d;

    logic load_en;
    logic grant_a;
    logic grant_b;
    logic transfer;

    // Grant selection and handshake: slot can load when empty or being drained this cycle
    always_comb begin
        load_en  = (state_q == StEmpty) || y_ready;
        grant_a  = a_valid && (!b_valid || !ptr_q);
        grant_b  = b_valid && (!a_valid || ptr_q);
        a_ready  = load_en && grant_a;
        b_ready  = load_en && grant_b;
        transfer = a_ready || b_ready;
    end

    // Next-state: load the granted word, drain to empty, or hold
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        s_d     = s_q;
        ptr_d   = ptr_q;
        if (transfer) begin
            state_d = StFull;
            y_d     = grant_b ? b : a;
            s_d     = grant_b;
            // Prefer the channel that lost this round
            ptr_d   = !grant_b;
        end else if ((state_q == StFull) && y_ready) begin
            // y and s keep their last values when the slot empties
            state_d = StEmpty;
        end
    end

    // State register with asynchronous reset discarding any held word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            y_q     <= '0;
            s_q     <= 1'b0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            s_q     <= s_d;
            ptr_q   <= ptr_d;
        end
    end

    // Output mapping
    always_comb begin
        y       = y_q;
        s       = s_q;
        y_valid = (state_q == StFull);
    end

endmodule

// File: tb/tb_arb2_rr.sv
// tb_arb2_rr: directed self-checking bench for arb2_rr.
module tb_arb2_rr;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b;
    logic       b_valid;
    logic       b_ready;
    logic [7:0] y;
    logic       y_valid;
    logic       y_ready;
    logic       s;

    int total = 0;
    int bad   = 0;

    arb2_rr #(.W(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .b       (b),
        .b_valid (b_valid),
        .b_ready (b_ready),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .s       (s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ey, input logic es,
                           input logic ev);
        chk({tag, ".y"}, {24'd0, y}, {24'd0, ey});
        chk({tag, ".s"}, {31'd0, s}, {31'd0, es});
        chk({tag, ".y_valid"}, {31'd0, y_valid}, {31'd0, ev});
    endtask

    task automatic chk_rdy(input string tag, input logic ea, input logic eb);
        chk({tag, ".a_ready"}, {31'd0, a_ready}, {31'd0, ea});
        chk({tag, ".b_ready"}, {31'd0, b_ready}, {31'd0, eb});
    endtask

    initial begin
        // Reset state
        rst = 1'b1; a = '0; b = '0; a_valid = 0; b_valid = 0; y_ready = 0;
        #3;
        chk_out("reset", 8'h00, 1'b0, 1'b0);
        chk_rdy("reset_idle", 1'b0, 1'b0);
        // Single A transfer; ready visible while still in reset
        a = 8'h11; a_valid = 1; y_ready = 1;
        #1;
        chk_rdy("reset_ready", 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("single_a", 8'h11, 1'b0, 1'b1);

        // Reset while full discards word; A preferred again
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_out("reset_full", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;

        // Contention alternates A, B, A, B
        a = 8'hA0; b = 8'hB0; a_valid = 1; b_valid = 1; y_ready = 1;
        #1;
        chk_rdy("rr0", 1'b1, 1'b0);
        tick();
        chk_out("rr1", 8'hA0, 1'b0, 1'b1);
        chk_rdy("rr1", 1'b0, 1'b1);
        tick();
        chk_out("rr2", 8'hB0, 1'b1, 1'b1);
        tick();
        chk_out("rr3", 8'hA0, 1'b0, 1'b1);
        tick();
        chk_out("rr4", 8'hB0, 1'b1, 1'b1);

        // Load 22 from A (ptr=0), then stall three cycles
        a = 8'h22;
        tick();
        chk_out("load22", 8'h22, 1'b0, 1'b1);
        y_ready = 0;
        #1;
        chk_rdy("stall", 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("stall_hold", 8'h22, 1'b0, 1'b1);
            chk_rdy("stall_hold", 1'b0, 1'b0);
        end
        // Pointer kept B preferred across the stall
        y_ready = 1;
        #1;
        chk_rdy("stall_release", 1'b0, 1'b1);
        tick();
        chk_out("after_stall", 8'hB0, 1'b1, 1'b1);

        // Only B valid twice back-to-back: no bubble
        a_valid = 0; b = 8'h33;
        #1;
        chk_rdy("b_only0", 1'b0, 1'b1);
        tick();
        chk_out("b_only1", 8'h33, 1'b1, 1'b1);
        chk_rdy("b_only1", 1'b0, 1'b1);
        tick();
        chk_out("b_only2", 8'h33, 1'b1, 1'b1);
        // ptr must be 0: contention goes to A
        a = 8'h55; a_valid = 1;
        #1;
        chk_rdy("ptr_after_b", 1'b1, 1'b0);
        tick();
        chk_out("load55", 8'h55, 1'b0, 1'b1);

        // Drain with no valids: empty, y and s hold
        a_valid = 0; b_valid = 0;
        #1;
        chk_rdy("drain", 1'b0, 1'b0);
        tick();
        chk_out("drained", 8'h55, 1'b0, 1'b0);

        // Empty accepts even with y_ready low; ptr=1 after A grant
        y_ready = 0; b = 8'h44; b_valid = 1;
        #1;
        chk_rdy("empty_load", 1'b0, 1'b1);
        tick();
        chk_out("load44", 8'h44, 1'b1, 1'b1);

        // Mid-cycle reset while full
        b_valid = 0;
        #2;
        rst = 1'b1;
        #1;
        chk_out("mid_reset", 8'h00, 1'b0, 1'b0);
        a = 8'h66; b = 8'h77; a_valid = 1; b_valid = 1;
        #1;
        chk_rdy("mid_reset_rdy", 1'b1, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("post_reset", 8'h66, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Bound the run in case stimulus stalls
    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
